// File: rtl/icache_model_pkg.sv
// Shared types, width helpers and data generation for the icache response model.
// The local struct layouts mirror the frontend fetch-port types.
package icache_model_pkg;

  localparam int unsigned VLEN        = 64;
  localparam int unsigned XLEN        = 64;
  localparam int unsigned FETCH_WIDTH = 32;

  localparam logic [XLEN-1:0] INSTR_ACCESS_FAULT = 64'd1;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS,
    KILL_MISS
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic            req;
    logic            kill_s1;
    logic            kill_s2;
    logic            spec;
    logic [VLEN-1:0] vaddr;
  } icache_dreq_i_t;

  typedef struct packed {
    logic                   ready;
    logic                   valid;
    logic [FETCH_WIDTH-1:0] data;
    logic [VLEN-1:0]        vaddr;
    exception_t             ex;
  } icache_dreq_o_t;

  function automatic int unsigned off_w(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int unsigned idx_w(input int unsigned nr_tags);
    return $clog2(nr_tags);
  endfunction

  function automatic int unsigned tag_w(input int unsigned nr_tags, input int unsigned line_bytes);
    return VLEN - idx_w(nr_tags) - off_w(line_bytes);
  endfunction

  // Word-aligned low address bits scrambled by the seed.
  function automatic logic [FETCH_WIDTH-1:0] gen_data(input logic [31:0] addr,
                                                      input logic [31:0] seed);
    logic [31:0] w;
    w = {addr[31:2], 2'b00} ^ seed;
    return FETCH_WIDTH'(w);
  endfunction

endpackage

// File: rtl/icache_resp_model_if.sv
// Fetch request/response bundle between a frontend (master) and the model (slave).
interface icache_resp_model_if;
  import icache_model_pkg::*;

  icache_dreq_i_t dreq_i;
  icache_dreq_o_t dreq_o;
  logic           flush_i;
  logic [31:0]    hit_cnt_o;
  logic [31:0]    miss_cnt_o;

  modport master (
    output dreq_i,
    output flush_i,
    input  dreq_o,
    input  hit_cnt_o,
    input  miss_cnt_o
  );

  modport slave (
    input  dreq_i,
    input  flush_i,
    output dreq_o,
    output hit_cnt_o,
    output miss_cnt_o
  );

endinterface

// File: rtl/icache_model_tags.sv
// Direct-mapped tag table: combinational lookup, single write port, bulk flush.
// A write in the same cycle as a flush survives, so an in-flight refill is never lost.
module icache_model_tags
  import icache_model_pkg::*;
#(
  parameter int unsigned NrTags    = 8,
  parameter int unsigned LineBytes = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [VLEN-1:0] lookup_vaddr,
  output logic            lookup_hit,
  input  logic            wr_en,
  input  logic [VLEN-1:0] wr_vaddr,
  input  logic            flush
);

  localparam int unsigned OffW = off_w(LineBytes);
  localparam int unsigned IdxW = idx_w(NrTags);
  localparam int unsigned TagW = tag_w(NrTags, LineBytes);

  logic [NrTags-1:0] valid_q, valid_d;
  logic [TagW-1:0]   tag_q [NrTags];
  logic [IdxW-1:0]   rd_idx, wr_idx;
  logic [TagW-1:0]   rd_tag, wr_tag;
  logic              unused_off;

  assign rd_idx = lookup_vaddr[OffW +: IdxW];
  assign rd_tag = lookup_vaddr[VLEN-1 -: TagW];
  assign wr_idx = wr_vaddr[OffW +: IdxW];
  assign wr_tag = wr_vaddr[VLEN-1 -: TagW];
  assign unused_off = ^{lookup_vaddr[OffW-1:0], wr_vaddr[OffW-1:0]};

  assign lookup_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  always_comb begin
    valid_d = flush ? '0 : valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) tag_q[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/icache_resp_model.sv
// Behavioural icache fetch responder: one outstanding request, 1-cycle hits,
// fixed-latency misses, kill_s1/kill_s2 handling and an access-fault window.
module icache_resp_model
  import icache_model_pkg::*;
#(
  parameter int unsigned NrTags      = 8,
  parameter int unsigned LineBytes   = 16,
  parameter int unsigned MissLatency = 6,
  parameter logic [63:0] FaultBase   = 64'h0,
  parameter logic [63:0] FaultSize   = 64'h0,
  parameter logic [31:0] DataSeed    = 32'hA5A5_0000
) (
  input logic               clk_i,
  input logic               rst_i,
  icache_resp_model_if.slave bus
);

  localparam int unsigned    CntW     = $clog2(MissLatency) + 1;
  localparam logic [CntW-1:0] MissLoad = CntW'(MissLatency - 2);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [VLEN-1:0] vaddr_p1, vaddr_d;
  logic [31:0]     hit_cnt_q, miss_cnt_q;
  logic            hit_inc, miss_inc, tag_wr;
  logic            vld_p1, fault_p1;
  logic            lookup_hit, in_fault, kill_s2;
  logic            unused_spec;
  icache_dreq_o_t  rsp;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign kill_s2     = bus.dreq_i.kill_s2;
  assign unused_spec = bus.dreq_i.spec;
  // Unsigned wrap makes addresses below the base fall outside the window.
  assign in_fault    = (vaddr_p1 - FaultBase) < FaultSize;

  icache_model_tags #(
    .NrTags    (NrTags),
    .LineBytes (LineBytes)
  ) u_tags (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lookup_vaddr (vaddr_p1),
    .lookup_hit   (lookup_hit),
    .wr_en        (tag_wr),
    .wr_vaddr     (vaddr_p1),
    .flush        (bus.flush_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      vaddr_p1   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vaddr_p1 <= vaddr_d;
      if (hit_inc)  hit_cnt_q  <= sat_inc(hit_cnt_q);
      if (miss_inc) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vaddr_d  = vaddr_p1;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    tag_wr   = 1'b0;
    vld_p1   = 1'b0;
    fault_p1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dreq_i.req && !bus.dreq_i.kill_s1) begin
          vaddr_d = bus.dreq_i.vaddr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (kill_s2) begin
          state_d = IDLE;
        end else if (in_fault) begin
          vld_p1   = 1'b1;
          fault_p1 = 1'b1;
          state_d  = IDLE;
        // A same-cycle flush invalidates the entry before it can hit.
        end else if (lookup_hit && !bus.flush_i) begin
          vld_p1  = 1'b1;
          hit_inc = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = MissLoad;
          state_d = MISS;
        end
      end
      MISS: begin
        if (cnt_q == '0) begin
          tag_wr  = 1'b1;
          state_d = IDLE;
          if (!kill_s2) begin
            vld_p1   = 1'b1;
            miss_inc = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (kill_s2) state_d = KILL_MISS;
        end
      end
      KILL_MISS: begin
        // Refill is already in flight: let it land silently.
        if (cnt_q == '0) begin
          tag_wr  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp          = '0;
    rsp.ready    = (state_q == IDLE);
    rsp.valid    = vld_p1;
    rsp.vaddr    = vaddr_p1;
    if (vld_p1 && !fault_p1) rsp.data = gen_data(vaddr_p1[31:0], DataSeed);
    if (fault_p1) begin
      rsp.ex.valid = 1'b1;
      rsp.ex.cause = INSTR_ACCESS_FAULT;
      rsp.ex.tval  = vaddr_p1;
    end
  end

  assign bus.dreq_o     = rsp;
  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_icache_resp_model.sv
// Randomised scoreboard bench for icache_resp_model with a line-level reference model.
module tb_icache_resp_model;
  import icache_model_pkg::*;

  localparam int          MISS_LAT = 6;
  localparam logic [63:0] F_BASE   = 64'h1000;
  localparam logic [63:0] F_SIZE   = 64'h100;
  localparam logic [31:0] SEED     = 32'hA5A5_0000;

  typedef struct {
    logic [63:0] vaddr;
    logic [31:0] data;
    logic        exv;
    logic [63:0] cause;
    logic [63:0] tval;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [63:0] m_line [8];
  bit          m_val  [8];
  int          m_hits = 0;
  int          m_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_resp_model_if bus();

  icache_resp_model #(
    .NrTags      (8),
    .LineBytes   (16),
    .MissLatency (MISS_LAT),
    .FaultBase   (F_BASE),
    .FaultSize   (F_SIZE),
    .DataSeed    (SEED)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_val[i] = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (bus.dreq_o.valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got valid vaddr 0x%0h, expected no response", bus.dreq_o.vaddr);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("rsp_vaddr", bus.dreq_o.vaddr, mon_e.vaddr);
        check("rsp_data", 64'(bus.dreq_o.data), 64'(mon_e.data));
        check("rsp_ex_valid", 64'(bus.dreq_o.ex.valid), 64'(mon_e.exv));
        check("rsp_ex_cause", bus.dreq_o.ex.cause, mon_e.cause);
        check("rsp_ex_tval", bus.dreq_o.ex.tval, mon_e.tval);
        check("rsp_ready_low", 64'(bus.dreq_o.ready), 64'd0);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.dreq_o.ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.dreq_o.ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got ready=%b, expected 1 within 20 cycles", bus.dreq_o.ready);
    end
  endtask

  // One fetch; k2/fl give the cycle offset after accept at which kill_s2/flush pulse (0 = none).
  task automatic fetch(input logic [63:0] a, input bit k1, input int k2, input int fl);
    int          acc, idx;
    logic [63:0] line;
    bit          flt, hit;
    exp_t        e;
    wait_ready();
    bus.dreq_i.req     = 1'b1;
    bus.dreq_i.kill_s1 = k1;
    bus.dreq_i.spec    = 1'($urandom_range(0, 1));
    bus.dreq_i.vaddr   = a;
    acc  = cyc;
    line = a >> 4;
    idx  = int'(line[2:0]);
    flt  = (a - F_BASE) < F_SIZE;
    e.vaddr = a;
    e.data  = (a[31:0] & 32'hFFFF_FFFC) ^ SEED;
    e.exv   = 1'b0;
    e.cause = '0;
    e.tval  = '0;
    if (k1 || k2 == 1) begin
      if (fl >= 1) model_clear();
    end else if (flt) begin
      e.data = '0; e.exv = 1'b1; e.cause = 64'd1; e.tval = a; e.cyc = acc + 1;
      sbq.push_back(e);
      if (fl >= 1) model_clear();
    end else begin
      hit = m_val[idx] && (m_line[idx] == line) && (fl != 1);
      if (hit) begin
        e.cyc = acc + 1;
        sbq.push_back(e);
        m_hits++;
        if (fl >= 1) model_clear();
      end else begin
        if (!(k2 >= 2 && k2 <= MISS_LAT)) begin
          e.cyc = acc + MISS_LAT;
          sbq.push_back(e);
          m_miss++;
        end
        if (fl >= 1 && fl <= MISS_LAT) model_clear();
        m_val[idx]  = 1'b1;
        m_line[idx] = line;
        if (fl > MISS_LAT) model_clear();
      end
    end
    @(posedge clk); #1;
    bus.dreq_i.req     = 1'b0;
    bus.dreq_i.kill_s1 = 1'b0;
    if (k1) check("kill_s1_ready", 64'(bus.dreq_o.ready), 64'd1);
    for (int c = 1; c <= MISS_LAT + 1; c++) begin
      bus.dreq_i.kill_s2 = (c == k2);
      bus.flush_i        = (c == fl);
      @(posedge clk); #1;
    end
    bus.dreq_i.kill_s2 = 1'b0;
    bus.flush_i        = 1'b0;
    check("hit_cnt", 64'(bus.hit_cnt_o), 64'(m_hits));
    check("miss_cnt", 64'(bus.miss_cnt_o), 64'(m_miss));
  endtask

  task automatic pulse_flush();
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    model_clear();
  endtask

  task automatic reset_mid_miss(input logic [63:0] a);
    wait_ready();
    bus.dreq_i.req   = 1'b1;
    bus.dreq_i.vaddr = a;
    @(posedge clk); #1;
    bus.dreq_i.req = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_ready", 64'(bus.dreq_o.ready), 64'd1);
    check("rst_hit_cnt", 64'(bus.hit_cnt_o), 64'd0);
    check("rst_miss_cnt", 64'(bus.miss_cnt_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    m_hits = 0;
    m_miss = 0;
    repeat (MISS_LAT + 2) @(posedge clk);
    #1;
    check("post_rst_miss_cnt", 64'(bus.miss_cnt_o), 64'd0);
  endtask

  function automatic logic [63:0] rand_addr();
    int          r;
    logic [63:0] base;
    r = int'($urandom_range(0, 99));
    if (r < 10) return F_BASE - 64'h8 + 64'(4 * $urandom_range(0, 67));
    case ($urandom_range(0, 2))
      0:       base = 64'h8000_0000;
      1:       base = 64'h8000_0080;
      default: base = 64'h8000_1000;
    endcase
    return base + 64'(16 * $urandom_range(0, 7)) + 64'(4 * $urandom_range(0, 3));
  endfunction

  initial begin
    bus.dreq_i = '0;
    bus.flush_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.dreq_o.ready), 64'd1);
    check("reset_valid", 64'(bus.dreq_o.valid), 64'd0);
    check("reset_data", 64'(bus.dreq_o.data), 64'd0);
    check("reset_ex_valid", 64'(bus.dreq_o.ex.valid), 64'd0);
    check("reset_hit_cnt", 64'(bus.hit_cnt_o), 64'd0);
    check("reset_miss_cnt", 64'(bus.miss_cnt_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    fetch(64'h8000_0000, 1'b0, 0, 0);
    fetch(64'h8000_0004, 1'b0, 0, 0);
    fetch(64'h9000_0000, 1'b1, 0, 0);
    fetch(64'h9000_0000, 1'b0, 3, 0);
    fetch(64'h9000_0008, 1'b0, 0, 0);
    fetch(64'h0000_10F0, 1'b0, 0, 0);
    fetch(64'h0000_1100, 1'b0, 0, 0);
    fetch(64'h0000_0FFC, 1'b0, 0, 0);
    fetch(64'h8000_0000, 1'b0, 0, 0);
    fetch(64'h8000_0000, 1'b0, 0, 0);
    pulse_flush();
    fetch(64'h8000_0000, 1'b0, 0, 0);
    fetch(64'h8000_0000, 1'b0, 0, 1);
    fetch(64'h8000_0020, 1'b0, 0, 3);
    fetch(64'h8000_0024, 1'b0, 0, 0);
    fetch(64'h8000_0040, 1'b0, 1, 0);

    for (int i = 0; i < 220; i++) begin
      bit k1;
      int k2, fl;
      k1 = ($urandom_range(0, 99) < 8);
      k2 = ($urandom_range(0, 99) < 20) ? int'($urandom_range(1, MISS_LAT + 1)) : 0;
      fl = ($urandom_range(0, 99) < 10) ? int'($urandom_range(1, MISS_LAT + 1)) : 0;
      fetch(rand_addr(), k1, k2, fl);
    end

    reset_mid_miss(64'hB000_0040);
    fetch(64'h8000_0000, 1'b0, 0, 0);
    fetch(64'h8000_000C, 1'b0, 0, 0);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
